// File: rtl/ov7670_line_writer.sv
// OV7670 byte-pair to RGB565 line-buffer writer with double-banked line addressing.
// Optional OV7670_LINE_WRITER_ERR_EN adds a sticky err_overflow flag for dropped pixels.
module ov7670_line_writer #(
  parameter int unsigned LINE_MAX = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  output logic        wr_ce,
  output logic [10:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        line_done,
  output logic        line_bank,
  output logic [9:0]  line_len,
`ifdef OV7670_LINE_WRITER_ERR_EN
  output logic        err_overflow,
`endif
  output logic        frame_start
);

  localparam logic [10:0] LINE_MAX_C = 11'(LINE_MAX);

  typedef enum logic [1:0] {WAIT_FRAME, LINE_WAIT, BYTE_HI, BYTE_LO} state_t;

  state_t      state, state_next;
  logic        vsync_q;
  logic        bank;
  logic [10:0] pix_cnt;
  logic [7:0]  hi;

  logic frame_go, hi_load, pix_go, pix_keep, line_end, abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_go   = 1'b0;
    hi_load    = 1'b0;
    pix_go     = 1'b0;
    line_end   = 1'b0;
    abort      = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (vsync_q && !vsync) begin
          frame_go   = 1'b1;
          state_next = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (vsync) begin
          abort      = 1'b1;
          state_next = WAIT_FRAME;
        end else if (href) begin
          hi_load    = 1'b1;
          state_next = BYTE_LO;
        end
      end
      BYTE_HI: begin
        if (vsync) begin
          abort      = 1'b1;
          state_next = WAIT_FRAME;
        end else if (href) begin
          hi_load    = 1'b1;
          state_next = BYTE_LO;
        end else begin
          line_end   = 1'b1;
          state_next = LINE_WAIT;
        end
      end
      BYTE_LO: begin
        if (vsync) begin
          abort      = 1'b1;
          state_next = WAIT_FRAME;
        end else if (href) begin
          pix_go     = 1'b1;
          state_next = BYTE_HI;
        end else begin
          // a high byte left without its partner is simply dropped
          line_end   = 1'b1;
          state_next = LINE_WAIT;
        end
      end
      default: state_next = WAIT_FRAME;
    endcase
  end

  assign pix_keep = pix_go && (pix_cnt < LINE_MAX_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      bank        <= 1'b0;
      pix_cnt     <= '0;
      hi          <= '0;
      wr_ce       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      line_done   <= 1'b0;
      line_bank   <= 1'b0;
      line_len    <= '0;
      frame_start <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      wr_ce       <= pix_keep;
      frame_start <= frame_go;
      line_done   <= 1'b0;
      if (hi_load) hi <= d;
      if (pix_keep) begin
        wr_addr <= {bank, pix_cnt[9:0]};
        wr_data <= {hi, d};
        pix_cnt <= pix_cnt + 11'd1;
      end
      if (frame_go) begin
        bank    <= 1'b0;
        pix_cnt <= '0;
      end
      if (line_end) begin
        if (pix_cnt != '0) begin
          line_done <= 1'b1;
          line_bank <= bank;
          line_len  <= pix_cnt[9:0];
          bank      <= ~bank;
        end
        pix_cnt <= '0;
      end
      if (abort) pix_cnt <= '0;
    end
  end

`ifdef OV7670_LINE_WRITER_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  err_overflow <= 1'b0;
    else if (frame_go)          err_overflow <= 1'b0;
    else if (pix_go && !pix_keep) err_overflow <= 1'b1;
  end
`endif

endmodule
